// File: rtl/inspect_uart_pkg.sv
// Shared types and constants for the inspect-word UART transmitter.
// INSPECT_UART_PARITY_EN adds the PARITY state (even parity, 8E1 frames).
package inspect_uart_pkg;

   localparam logic [7:0] ASCII_CR  = 8'h0D;
   localparam logic [7:0] ASCII_LF  = 8'h0A;
   localparam logic [7:0] ASCII_0   = 8'h30;
   localparam logic [7:0] ASCII_A   = 8'h41;
   localparam int         NUM_CHARS = 10;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef INSPECT_UART_PARITY_EN
      PARITY,
`endif
      STOP
   } state_e;

   typedef enum logic {
      CTL_IDLE,
      CTL_RUN
   } ctl_e;

   function automatic logic [7:0] nibble_to_hex(input logic [3:0] n);
      if (n < 4'd10) return ASCII_0 + {4'h0, n};
      return ASCII_A + {4'h0, n} - 8'd10;
   endfunction

endpackage

// File: rtl/inspect_uart_tx_if.sv
// Requester-side bundle of the inspect UART: word, request, status and line.
interface inspect_uart_tx_if;
   logic [31:0] data_in;
   logic        send;
   logic        busy;
   logic        done;
   logic        tx;

   modport master (output data_in, send, input busy, done, tx);
   modport slave  (input data_in, send, output busy, done, tx);
endinterface

// File: rtl/uart_tx_byte.sv
// Bit-level serializer: one frame per start, LSB first, registered tx.
// With INSPECT_UART_PARITY_EN an even-parity bit follows d7.
module uart_tx_byte
   import inspect_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] byte_in,
   input  logic       start,
   output logic       tx,
   output logic       byte_done
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_q, bit_d;
   logic             tx_q, tx_d;
   logic             last;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         tx_q    <= tx_d;
      end
   end

   always_comb begin
      last      = (cnt_q == CNT_LAST);
      state_d   = state_q;
      bit_d     = bit_q;
      byte_done = 1'b0;
      cnt_d     = last ? '0 : cnt_q + 1'b1;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (start) state_d = START;
         end
         START: if (last) state_d = DATA;
         DATA: begin
            if (last) begin
               bit_d = bit_q + 3'd1;
`ifdef INSPECT_UART_PARITY_EN
               if (bit_q == 3'd7) state_d = PARITY;
`else
               if (bit_q == 3'd7) state_d = STOP;
`endif
            end
         end
`ifdef INSPECT_UART_PARITY_EN
         PARITY: if (last) state_d = STOP;
`endif
         STOP: begin
            // Chaining straight into START keeps characters gap-free.
            if (last) begin
               byte_done = 1'b1;
               state_d   = start ? START : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (state_d != state_q) cnt_d = '0;

      // tx is driven from the next state so the line changes on the edge itself.
      tx_d = 1'b1;
      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = byte_in[bit_d];
`ifdef INSPECT_UART_PARITY_EN
         PARITY:  tx_d = ^byte_in;
`endif
         default: tx_d = 1'b1;
      endcase
   end

   assign tx = tx_q;

endmodule

// File: rtl/inspect_uart_tx.sv
// Sends a captured 32-bit inspect word as 8 hex ASCII chars plus CR LF.
// INSPECT_UART_PARITY_EN selects 8E1 framing in the serializer.
module inspect_uart_tx
   import inspect_uart_pkg::*;
#(
   parameter int CLK_FREQ_HZ = 50_000_000,
   parameter int BAUD        = 115200
) (
   input  logic             clk,
   input  logic             rst,
   inspect_uart_tx_if.slave bus
);

   localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
   localparam logic [3:0] LAST_IDX = 4'(NUM_CHARS - 1);

   ctl_e        ctl_q, ctl_d;
   logic [31:0] shadow_q, shadow_d;
   logic [3:0]  idx_q, idx_d;
   logic        done_q, done_d;
   logic        start;
   logic        byte_done;
   logic        tx_w;
   logic [7:0]  char_byte;
   logic [31:0] shifted;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ctl_q    <= CTL_IDLE;
         shadow_q <= '0;
         idx_q    <= '0;
         done_q   <= 1'b0;
      end else begin
         ctl_q    <= ctl_d;
         shadow_q <= shadow_d;
         idx_q    <= idx_d;
         done_q   <= done_d;
      end
   end

   always_comb begin
      ctl_d    = ctl_q;
      shadow_d = shadow_q;
      idx_d    = idx_q;
      done_d   = 1'b0;
      start    = 1'b0;
      case (ctl_q)
         CTL_IDLE: begin
            if (bus.send) begin
               shadow_d = bus.data_in;
               idx_d    = '0;
               start    = 1'b1;
               ctl_d    = CTL_RUN;
            end
         end
         CTL_RUN: begin
            if (byte_done) begin
               if (idx_q == LAST_IDX) begin
                  ctl_d  = CTL_IDLE;
                  done_d = 1'b1;
               end else begin
                  idx_d = idx_q + 4'd1;
                  start = 1'b1;
               end
            end
         end
         default: ctl_d = CTL_IDLE;
      endcase
   end

   // The serializer only reads the byte from DATA onward, by which time
   // shadow_q and idx_q already hold the values for that character.
   always_comb begin
      shifted = shadow_q << {idx_q[2:0], 2'b00};
      case (idx_q)
         4'd8:    char_byte = ASCII_CR;
         4'd9:    char_byte = ASCII_LF;
         default: char_byte = nibble_to_hex(shifted[31:28]);
      endcase
   end

   uart_tx_byte #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_byte (
      .clk       (clk),
      .rst       (rst),
      .byte_in   (char_byte),
      .start     (start),
      .tx        (tx_w),
      .byte_done (byte_done)
   );

   assign bus.tx   = tx_w;
   assign bus.busy = (ctl_q == CTL_RUN);
   assign bus.done = done_q;

endmodule

// File: doc/inspect_uart_tx.md
# inspect_uart_tx

Serial debug output stage that sits directly downstream of the single-cycle processor top. It consumes the 32-bit inspect word the processor exports and sends it over an RS-232 line on the DE2-115 as eight uppercase hex ASCII characters followed by CR LF. It captures the word on a one-cycle `send` request, runs a character sequencer and a bit-level serializer, and reports `busy` and `done` back to the requester.

## Interface
- `CLK_FREQ_HZ`, default 50_000_000: system clock frequency.
- `BAUD`, default 115200: line rate.
- `CLKS_PER_BIT`, default CLK_FREQ_HZ/BAUD (434): derived local constant; must be ≥ 2.

Ports:
- `clk`  in  1: system clock; all logic is on the rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `data_in`  in  32: inspect word from the processor.
- `send`  in  1: transmit request, sampled every cycle.
- `busy`  out  1: a transmission is in progress.
- `done`  out  1: one-cycle pulse when the transmission completes.
- `tx`  out  1: serial line, idle high.

## Operation
- **Reset values:** `tx`=1, `busy`=0, `done`=0, state=IDLE, all counters 0.
- **Accepting a request:** `send`=1 while in IDLE copies `data_in` into a shadow register. The character index is set to 0 and the state moves to START.
  - `send` is ignored in every other state.
  - Later changes to `data_in` have no effect on the word being sent.
- **Character sequence:** 10 characters.
  - Index 0..7: nibble [31-4i:28-4i] of the shadow word, most significant nibble first. Nibble 0-9 maps to 0x30-0x39; nibble A-F maps to 0x41-0x46.
  - Index 8: 0x0D (CR).
  - Index 9: 0x0A (LF).
- **Character frame:** 8N1, LSB first: start bit 0, data bits d0..d7, stop bit 1. Every bit lasts exactly CLKS_PER_BIT cycles.
- **Byte FSM states:**
  - IDLE: stays here until an accepted `send`.
  - START: goes to DATA after one bit time.
  - DATA: goes to STOP after 8 bit times.
  - STOP: after one bit time, goes to START if the index is below 9 (index incremented), otherwise to IDLE.
- **Bit counters:**
  - The baud counter runs 0..CLKS_PER_BIT-1 and wraps; it is cleared on every state change. Its width is $clog2(CLKS_PER_BIT).
  - The bit index is 3 bits and wraps within DATA only.
- **Completion:** on the final STOP→IDLE transition, `done` is 1 for exactly one cycle and `busy` returns to 0 in that same cycle. A `send` in that cycle is accepted.
- **Reset during a transmission:** the character in flight is abandoned, `tx` goes to 1 immediately, and no `done` is produced.

## Timing
- `send` is sampled at edge N. At edge N, `busy` goes to 1 and `tx` goes to 0 (the start bit); both are registered outputs.
- Each character takes 10×CLKS_PER_BIT cycles (11× when parity is enabled).
- Total transmission is 100×CLKS_PER_BIT cycles (110× with parity). `done` is asserted for the cycle that begins exactly that many cycles after edge N.
- There is no gap between consecutive characters; one character's stop bit is followed directly by the next start bit.

## Configuration
- **`INSPECT_UART_PARITY_EN` defined:** an even-parity bit (XOR of d0..d7) is sent between d7 and the stop bit. This adds a PARITY state (DATA→PARITY→STOP) and makes each frame 11 bits.
- **`INSPECT_UART_PARITY_EN` not defined:** plain 8N1 as described above. The PARITY state and its logic are not present.

## Structure
- **Package `inspect_uart_pkg`:**
  - State enum (IDLE, START, DATA, PARITY, STOP).
  - ASCII constants for CR, LF, '0' and 'A'.
  - Character count constant (10).
  - Function `nibble_to_hex(4-bit) → 8-bit`.
- **Sub-module `uart_tx_byte`:** the byte serializer.
  - Inputs: byte, start.
  - Outputs: `tx`, byte_done.
  - Holds the baud counter, bit index and the START/DATA/(PARITY)/STOP states.
- **Top level:** holds the shadow register, the character index and the IDLE/active control, and sequences `uart_tx_byte`.

## Test plan
All scenarios use CLK_FREQ_HZ=1000 and BAUD=100, giving CLKS_PER_BIT=10.
- **Reset:** assert `rst` for 3 cycles → `tx`=1, `busy`=0 and `done`=0 throughout; they stay so with no `send`.
- **Full word:** `send` one cycle with `data_in`=32'hDEADBEEF → decoded bytes are 44 45 41 44 42 45 45 46 0D 0A. `busy` stays high for 1000 cycles, then `done` is a single-cycle pulse.
- **Capture and ignore:** `data_in`=32'h0000000F with `send`, then change `data_in` to 32'h12345678 and pulse `send` at cycle 50 → the bench receives only "0000000F\r\n", and there is exactly one `done`.
- **Back-to-back:** pulse `send` in the same cycle `done` is high → the next start bit begins on that edge, with no idle bit between the two transmissions.
- **Reset mid-character:** assert `rst` at cycle 235 → `tx`=1 immediately and `busy`=0. After release, `send` with 32'h00000001 → clean "00000001\r\n".
- **Parity (macro defined):** send 32'h7000000A → the '7' (0x37) frame has parity bit 1; the '0' frames have parity bit 0; the 'A' (0x41) frame has parity bit 0. `busy` stays high for 1100 cycles.
